fault_map_transmitter: RTL and testbench

- Transmitting end of the fault-map path from the Diagnostic_loop_chains to the BISR faulty-PE storage.
- After a diagnosis pass, reads per-row detection results from the DLC, row by row.
- Merges them into one faulty-PE bitmap per row and transmits each bitmap to the BISR over a valid/ready write handshake.
- Reports per-pass fault statistics and a done pulse to hybrid_bist.

---
 rtl/fault_map_transmitter.sv | 144 ++++++++++++++
 tb/tb_fault_map_transmitter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_map_transmitter.sv
// fault_map_transmitter
// Reads per-row detection results from the diagnostic loop chains, merges
// them into one faulty-PE bitmap per row and writes each bitmap to the BISR
// storage, in ascending row order. Keeps per-pass fault statistics and pulses
// done once the last row has been accepted.
//
// Write handshake: wr_en (valid) is high only in SEND. wr_addr and
// faulty_pattern are held stable while wr_en is high. A bitmap transfers on a
// rising edge where wr_en && wr_ready. wr_ready is ignored at all other times.
//
// DLC read: detection_en is high for exactly one cycle per row (REQ), with
// detection_addr = row. The DLC answers one cycle later, which is the CAPT
// cycle in which the inputs are sampled.
module fault_map_transmitter #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
  parameter int CNT_WIDTH     = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE)+1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     detection_en,
  output logic [ADDR_WIDTH-1:0]    detection_addr,
  input  logic [SYSTOLIC_SIZE-1:0] single_pe_detection,
  input  logic [SYSTOLIC_SIZE-1:0] column_fault_detection,
  input  logic                     row_fault_detection,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [SYSTOLIC_SIZE-1:0] faulty_pattern,
  output logic [CNT_WIDTH-1:0]     fault_count,
  output logic [ADDR_WIDTH:0]      row_fault_count,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CAPT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE-1);

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    row_q, row_d;
  logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [SYSTOLIC_SIZE-1:0] pattern_q, pattern_d;
  logic [CNT_WIDTH-1:0]     fault_cnt_q, fault_cnt_d;
  logic [ADDR_WIDTH:0]      row_fault_cnt_q, row_fault_cnt_d;

  logic [SYSTOLIC_SIZE-1:0] new_pattern;
  logic [CNT_WIDTH-1:0]     new_ones;

  // Merge the DLC answer into a bitmap: a whole-row fault marks every PE.
  always_comb begin
    new_pattern = row_fault_detection ? {SYSTOLIC_SIZE{1'b1}}
                                      : (single_pe_detection | column_fault_detection);
    new_ones = '0;
    for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
      new_ones = new_ones + CNT_WIDTH'(new_pattern[i]);
    end
  end

  // Next-state and datapath updates for the row-by-row transfer FSM.
  always_comb begin
    state_d         = state_q;
    row_d           = row_q;
    wr_addr_d       = wr_addr_q;
    pattern_d       = pattern_q;
    fault_cnt_d     = fault_cnt_q;
    row_fault_cnt_d = row_fault_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          fault_cnt_d     = '0;
          row_fault_cnt_d = '0;
          row_d           = '0;
          state_d         = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        pattern_d       = new_pattern;
        wr_addr_d       = row_q;
        fault_cnt_d     = fault_cnt_q + new_ones;
        row_fault_cnt_d = row_fault_cnt_q + (ADDR_WIDTH+1)'(row_fault_detection);
        state_d         = S_SEND;
      end
      S_SEND: begin
        // Hold the bitmap until the BISR takes it; no timeout.
        if (wr_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any partial pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      row_q           <= '0;
      wr_addr_q       <= '0;
      pattern_q       <= '0;
      fault_cnt_q     <= '0;
      row_fault_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      wr_addr_q       <= wr_addr_d;
      pattern_q       <= pattern_d;
      fault_cnt_q     <= fault_cnt_d;
      row_fault_cnt_q <= row_fault_cnt_d;
    end
  end

  assign detection_en    = (state_q == S_REQ);
  assign detection_addr  = (state_q == S_REQ) ? row_q : '0;
  assign wr_en           = (state_q == S_SEND);
  assign wr_addr         = wr_addr_q;
  assign faulty_pattern  = pattern_q;
  assign fault_count     = fault_cnt_q;
  assign row_fault_count = row_fault_cnt_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_fault_map_transmitter.sv
// Bench for fault_map_transmitter: a DLC responder model, a bitmap model
// computed from the merge rules, and per-scenario tasks.
module tb_fault_map_transmitter;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int CW = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start;
  logic          detection_en;
  logic [AW-1:0] detection_addr;
  logic [N-1:0]  single_pe_detection;
  logic [N-1:0]  column_fault_detection;
  logic          row_fault_detection;
  logic          wr_en;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  faulty_pattern;
  logic [CW-1:0] fault_count;
  logic [AW:0]   row_fault_count;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  fault_map_transmitter #(.SYSTOLIC_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .detection_en(detection_en), .detection_addr(detection_addr),
    .single_pe_detection(single_pe_detection),
    .column_fault_detection(column_fault_detection),
    .row_fault_detection(row_fault_detection),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .faulty_pattern(faulty_pattern), .fault_count(fault_count),
    .row_fault_count(row_fault_count), .busy(busy), .done(done)
  );

  // ---------------- DLC model ----------------
  logic [N-1:0] dlc_single [N];
  logic [N-1:0] dlc_col    [N];
  logic         dlc_rowf   [N];

  // Answer a read one cycle later; drive junk otherwise so a mistimed sample shows.
  always @(posedge clk) begin
    if (detection_en) begin
      single_pe_detection    <= dlc_single[detection_addr];
      column_fault_detection <= dlc_col[detection_addr];
      row_fault_detection    <= dlc_rowf[detection_addr];
    end else begin
      single_pe_detection    <= N'($urandom);
      column_fault_detection <= N'($urandom);
      row_fault_detection    <= 1'($urandom);
    end
  end

  function automatic int ones(input logic [N-1:0] v);
    int n = 0;
    for (int i = 0; i < N; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic clear_dlc();
    for (int r = 0; r < N; r++) begin
      dlc_single[r] = '0; dlc_col[r] = '0; dlc_rowf[r] = 1'b0;
    end
  endtask

  task automatic random_dlc();
    for (int r = 0; r < N; r++) begin
      dlc_single[r] = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      dlc_col[r]    = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N-1)) : '0;
      dlc_rowf[r]   = ($urandom_range(0, 5) == 0);
    end
  endtask

  // ---------------- driver + scoreboard for one pass ----------------
  // stall_row/stall_len: hold wr_ready low for stall_len cycles on that row.
  // restart_row: pulse start again while that row is being requested.
  task automatic do_pass(input string name, input int stall_row, input int stall_len,
                         input int restart_row, input bit rand_ready);
    logic [AW+N-1:0] exp_q[$];
    logic [AW+N-1:0] exp_w;
    logic [N-1:0]    pat;
    logic [N-1:0]    held_pat;
    logic [AW-1:0]   held_addr;
    bit              have_held = 0;
    bit              restarted = 0;
    int exp_faults = 0, exp_rowf = 0;
    int cyc = 0, dones = 0, done_cyc = -1, stalled = 0, accepted = 0;

    for (int r = 0; r < N; r++) begin
      pat = dlc_rowf[r] ? {N{1'b1}} : (dlc_single[r] | dlc_col[r]);
      exp_q.push_back({AW'(r), pat});
      exp_faults += ones(pat);
      exp_rowf   += int'(dlc_rowf[r]);
    end

    @(negedge clk);
    start    = 1'b1;
    wr_ready = 1'b1;
    while (cyc < 150 && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (detection_en && detection_addr == restart_row && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      if (detection_en) begin
        checks++;
        if (detection_addr !== AW'(accepted)) begin
          errors++;
          $display("FAIL %s req_order: detection_addr=%0d required=%0d", name, detection_addr, accepted);
        end
        checks++;
        if (wr_en !== 1'b0) begin
          errors++;
          $display("FAIL %s req_vs_write: wr_en=%b required=0 while detection_en", name, wr_en);
        end
      end
      if (wr_en) begin
        if (have_held && wr_addr == stall_row) begin
          checks++;
          if (wr_addr !== held_addr || faulty_pattern !== held_pat) begin
            errors++;
            $display("FAIL %s hold_stable: addr=%0d pat=%h required addr=%0d pat=%h",
                     name, wr_addr, faulty_pattern, held_addr, held_pat);
          end
        end
        if (wr_addr == stall_row && stalled < stall_len) begin
          if (!have_held) begin
            held_addr = wr_addr; held_pat = faulty_pattern; have_held = 1;
          end
          wr_ready = 1'b0;
          stalled++;
        end else begin
          wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (wr_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s extra_write: addr=%0d pat=%h required none", name, wr_addr, faulty_pattern);
          end else begin
            exp_w = exp_q.pop_front();
            if ({wr_addr, faulty_pattern} !== exp_w) begin
              errors++;
              $display("FAIL %s write: addr=%0d pat=%h required addr=%0d pat=%h",
                       name, wr_addr, faulty_pattern, exp_w[AW+N-1:N], exp_w[N-1:0]);
            end
          end
          accepted++;
        end
      end else begin
        wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_at_done: busy=%b required=1", name, busy);
          end
        end
      end
    end
    start    = 1'b0;
    wr_ready = 1'b1;

    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, cyc);
    end else if (!rand_ready && done_cyc != 3*N + 1 + stall_len) begin
      errors++;
      $display("FAIL %s latency: done at cycle %0d required %0d", name, done_cyc, 3*N + 1 + stall_len);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL %s done_pulses: count=%0d required=1", name, dones);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_writes: left=%0d required=0", name, exp_q.size());
    end
    checks++;
    if (fault_count !== CW'(exp_faults)) begin
      errors++;
      $display("FAIL %s fault_count: got=%0d required=%0d", name, fault_count, exp_faults);
    end
    checks++;
    if (row_fault_count !== (AW+1)'(exp_rowf)) begin
      errors++;
      $display("FAIL %s row_fault_count: got=%0d required=%0d", name, row_fault_count, exp_rowf);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after: busy=%b required=0", name, busy);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({detection_en, detection_addr, wr_en, wr_addr, faulty_pattern,
         fault_count, row_fault_count, busy, done} !== '0) begin
      errors++;
      $display("FAIL %s outputs_zero: den=%b daddr=%0d wen=%b waddr=%0d pat=%h fc=%0d rfc=%0d busy=%b done=%b required all 0",
               name, detection_en, detection_addr, wr_en, wr_addr, faulty_pattern,
               fault_count, row_fault_count, busy, done);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b0;
    clear_dlc();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("after_reset");
  endtask

  task automatic test_all_zero();
    clear_dlc();
    do_pass("all_zero", -1, 0, -1, 0);
  endtask

  task automatic test_single_and_column();
    clear_dlc();
    for (int r = 0; r < N; r++) dlc_col[r] = 8'b0000_0001;
    dlc_single[3] = 8'b0001_0000;
    do_pass("single_col", -1, 0, -1, 0);
  endtask

  task automatic test_row_fault();
    clear_dlc();
    dlc_rowf[5]   = 1'b1;
    dlc_single[5] = 8'h02;
    do_pass("row_fault", -1, 0, -1, 0);
  endtask

  task automatic test_backpressure();
    random_dlc();
    do_pass("stall_row2", 2, 4, -1, 0);
  endtask

  task automatic test_start_while_busy();
    random_dlc();
    do_pass("restart_row4", -1, 0, 4, 0);
  endtask

  task automatic test_reset_mid_pass();
    int cyc = 0;
    clear_dlc();
    for (int r = 0; r < N; r++) dlc_col[r] = 8'h81;
    @(negedge clk);
    start = 1'b1; wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 100 && !(wr_en && wr_addr == 3'd6)) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!(wr_en && wr_addr == 3'd6)) begin
      errors++;
      $display("FAIL mid_reset reach_row6: wr_en=%b wr_addr=%0d required 1 and 6", wr_en, wr_addr);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_reset_idle");
    random_dlc();
    do_pass("after_mid_reset", -1, 0, -1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      random_dlc();
      do_pass($sformatf("random%0d", k), -1, 0, -1, 1);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_and_column();
    test_row_fault();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_pass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
